// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/interrupt sequencer (drain, trap/mret, redirect).
// Optional macro TRAP_LAT_CNT_EN adds lat_cur/lat_max interrupt-latency counters.
module trap_ctrl #(
  parameter int VECTORED_SUP = 1,
  parameter int LAT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] mip_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        mret_req,
  input  logic [31:0] next_pc,
  input  logic        pipe_idle,
  input  logic        redirect_ready,
  output logic        stall_req,
  output logic        flush,
  output logic        trap_set,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic        mret,
  output logic        cu_intr_ack,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
`ifdef TRAP_LAT_CNT_EN
  output logic [LAT_W-1:0] lat_cur,
  output logic [LAT_W-1:0] lat_max,
`endif
  output logic        busy
);

  localparam logic [31:0] C_MEI = 32'h8000000B;
  localparam logic [31:0] C_MSI = 32'h80000003;
  localparam logic [31:0] C_MTI = 32'h80000007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP,
    S_MRET,
    S_REDIR
  } state_t;

  state_t      r_state, w_nxt;
  logic [31:0] r_cause, w_cause;
  logic [31:0] r_tpc, w_tpc;
  logic [31:0] r_tgt, w_tgt;

  logic [2:0]  w_irq;
  logic        w_int_take;
  logic [31:0] w_irq_cause;
  logic [31:0] w_base;
  logic [31:0] w_vtgt;
  logic        w_vec;

  logic        r_stall, r_flush, r_tset, r_mret;
  logic        r_ack, r_rv;
  logic [31:0] r_tcause, r_ttpc, r_rpc;

  logic        w_unused;

  assign w_irq = {mie_in[11] & mip_in[11],
                  mie_in[3]  & mip_in[3],
                  mie_in[7]  & mip_in[7]};
  assign w_int_take = mstatus_in[3] & (|w_irq);

  assign w_base = {mtvec_in[31:2], 2'b00};
  assign w_vec  = (VECTORED_SUP != 0) &&
                  (mtvec_in[1:0] == 2'b01) && r_cause[31];
  assign w_vtgt = w_base + {25'd0, r_cause[4:0], 2'b00};

  assign w_unused = ^{mstatus_in[31:4], mstatus_in[2:0],
                      mie_in[31:12], mie_in[10:8],
                      mie_in[6:4], mie_in[2:0],
                      mip_in[31:12], mip_in[10:8],
                      mip_in[6:4], mip_in[2:0]};

  // pick the highest-priority pending interrupt: MEI > MSI > MTI
  always_comb begin
    w_irq_cause = C_MTI;
    if (w_irq[2])      w_irq_cause = C_MEI;
    else if (w_irq[1]) w_irq_cause = C_MSI;
  end

  // next-state and latched trap data
  always_comb begin
    w_nxt   = r_state;
    w_cause = r_cause;
    w_tpc   = r_tpc;
    w_tgt   = r_tgt;
    case (r_state)
      S_IDLE: begin
        if (exc_valid) begin
          w_nxt   = S_TRAP;
          w_cause = {28'd0, exc_code};
          w_tpc   = exc_pc;
        end else if (mret_req) begin
          w_nxt = S_MRET;
        end else if (w_int_take) begin
          w_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (exc_valid) begin
          w_nxt   = S_TRAP;
          w_cause = {28'd0, exc_code};
          w_tpc   = exc_pc;
        end else if (pipe_idle && w_int_take) begin
          w_nxt   = S_TRAP;
          w_cause = w_irq_cause;
          w_tpc   = next_pc;
        end else if (pipe_idle) begin
          w_nxt = S_IDLE;
        end
      end
      S_TRAP: begin
        w_nxt = S_REDIR;
        w_tgt = w_vec ? w_vtgt : w_base;
      end
      S_MRET: begin
        w_nxt = S_REDIR;
        w_tgt = mepc_in;
      end
      S_REDIR: begin
        if (redirect_ready) begin
          w_nxt   = S_IDLE;
          w_cause = '0;
          w_tpc   = '0;
          w_tgt   = '0;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // state and latched data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_tpc   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cause <= w_cause;
      r_tpc   <= w_tpc;
      r_tgt   <= w_tgt;
    end
  end

  // outputs registered from the next-state decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall  <= 1'b0;
      r_flush  <= 1'b0;
      r_tset   <= 1'b0;
      r_mret   <= 1'b0;
      r_ack    <= 1'b0;
      r_rv     <= 1'b0;
      r_tcause <= '0;
      r_ttpc   <= '0;
      r_rpc    <= '0;
    end else begin
      r_stall  <= (w_nxt != S_IDLE);
      r_flush  <= (w_nxt == S_TRAP) || (w_nxt == S_MRET);
      r_tset   <= (w_nxt == S_TRAP);
      r_mret   <= (w_nxt == S_MRET);
      r_ack    <= (w_nxt == S_TRAP) && (w_cause == C_MEI);
      r_rv     <= (w_nxt == S_REDIR);
      r_tcause <= (w_nxt == S_TRAP) ? w_cause : '0;
      r_ttpc   <= (w_nxt == S_TRAP) ? w_tpc : '0;
      r_rpc    <= (w_nxt == S_REDIR) ? w_tgt : '0;
    end
  end

  assign stall_req      = r_stall;
  assign busy           = r_stall;
  assign flush          = r_flush;
  assign trap_set       = r_tset;
  assign mret           = r_mret;
  assign cu_intr_ack    = r_ack;
  assign redirect_valid = r_rv;
  assign trap_cause     = r_tcause;
  assign trap_pc        = r_ttpc;
  assign redirect_pc    = r_rpc;

`ifdef TRAP_LAT_CNT_EN
  logic [LAT_W-1:0] r_lat_cur, r_lat_max, w_lat_inc;

  assign w_lat_inc = (&r_lat_cur) ? r_lat_cur : r_lat_cur + LAT_W'(1);

  // drain-cycle counter and worst-case interrupt latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cur <= '0;
      r_lat_max <= '0;
    end else begin
      if (r_state == S_IDLE && w_nxt == S_DRAIN)
        r_lat_cur <= '0;
      else if (r_state == S_DRAIN)
        r_lat_cur <= w_lat_inc;
      if (r_state == S_DRAIN && w_nxt == S_TRAP &&
          w_cause[31] && (w_lat_inc > r_lat_max))
        r_lat_max <= w_lat_inc;
    end
  end

  assign lat_cur = r_lat_cur;
  assign lat_max = r_lat_max;
`else
  localparam int unused_lat_w = LAT_W;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table plus reset-in-redirect sequence.
// Runs a vectored and a direct-only instance side by side.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mstatus_in, mie_in, mip_in, mtvec_in, mepc_in;
  logic        exc_valid, mret_req, pipe_idle, redirect_ready;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, next_pc;

  logic        a_stall, a_flush, a_tset, a_mret, a_ack, a_rv, a_busy;
  logic [31:0] a_cause, a_tpc, a_rpc;
  logic        b_stall, b_flush, b_tset, b_mret, b_ack, b_rv, b_busy;
  logic [31:0] b_cause, b_tpc, b_rpc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED_SUP(1)) u_a (
    .clk(clk), .reset(reset),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mip_in(mip_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .mret_req(mret_req), .next_pc(next_pc), .pipe_idle(pipe_idle),
    .redirect_ready(redirect_ready),
    .stall_req(a_stall), .flush(a_flush), .trap_set(a_tset),
    .trap_cause(a_cause), .trap_pc(a_tpc), .mret(a_mret),
    .cu_intr_ack(a_ack), .redirect_valid(a_rv),
    .redirect_pc(a_rpc), .busy(a_busy)
  );

  trap_ctrl #(.VECTORED_SUP(0)) u_b (
    .clk(clk), .reset(reset),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mip_in(mip_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .mret_req(mret_req), .next_pc(next_pc), .pipe_idle(pipe_idle),
    .redirect_ready(redirect_ready),
    .stall_req(b_stall), .flush(b_flush), .trap_set(b_tset),
    .trap_cause(b_cause), .trap_pc(b_tpc), .mret(b_mret),
    .cu_intr_ack(b_ack), .redirect_valid(b_rv),
    .redirect_pc(b_rpc), .busy(b_busy)
  );

  // flag order: {stall, flush, trap_set, mret, ack, rv, busy}
  localparam logic [6:0] F_IDL = 7'b0000000;
  localparam logic [6:0] F_DRN = 7'b1000001;
  localparam logic [6:0] F_TRP = 7'b1110001;
  localparam logic [6:0] F_TPA = 7'b1110101;
  localparam logic [6:0] F_MRT = 7'b1101001;
  localparam logic [6:0] F_RDR = 7'b1000011;

  typedef struct {
    logic [31:0] mst, mip, mtv, mepc, npc;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] epc;
    logic        mr, idle, rdy;
    logic [6:0]  ef;
    logic [31:0] ec, et, er, er2;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic [31:0] mst, mip, mtv, mepc, npc,
    input logic exc, input logic [3:0] code,
    input logic [31:0] epc, input logic mr, idle, rdy,
    input logic [6:0] ef,
    input logic [31:0] ec, et, er, er2);
    vec_t v;
    v.mst = mst; v.mip = mip; v.mtv = mtv;
    v.mepc = mepc; v.npc = npc; v.exc = exc;
    v.code = code; v.epc = epc; v.mr = mr;
    v.idle = idle; v.rdy = rdy; v.ef = ef;
    v.ec = ec; v.et = et; v.er = er; v.er2 = er2;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, row, act, exp);
    end
  endtask

  function automatic logic [6:0] fa();
    return {a_stall, a_flush, a_tset, a_mret, a_ack, a_rv, a_busy};
  endfunction

  function automatic logic [6:0] fb();
    return {b_stall, b_flush, b_tset, b_mret, b_ack, b_rv, b_busy};
  endfunction

  task automatic chk_all(input string nm, input int row,
                         input logic [6:0] ef,
                         input logic [31:0] ec, et, er, er2);
    chk({nm, "_flags_a"}, row, {25'd0, fa()}, {25'd0, ef});
    chk({nm, "_flags_b"}, row, {25'd0, fb()}, {25'd0, ef});
    chk({nm, "_cause"}, row, a_cause, ec);
    chk({nm, "_tpc"}, row, a_tpc, et);
    chk({nm, "_rpc_a"}, row, a_rpc, er);
    chk({nm, "_rpc_b"}, row, b_rpc, er2);
  endtask

  initial begin
    reset = 1'b0;
    mstatus_in = 32'h8; mie_in = 32'h888; mip_in = '0;
    mtvec_in = 32'h200; mepc_in = '0; next_pc = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0;
    mret_req = 1'b0; pipe_idle = 1'b0; redirect_ready = 1'b1;

    // exception ecall-M
    add(8, 0, 'h200, 0, 0, 1, 11, 'h100, 0, 0, 1, F_TRP, 'hB, 'h100, 0, 0);
    add(8, 0, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, F_RDR, 0, 0, 'h200, 'h200);
    add(8, 0, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    // external interrupt, 3-cycle drain
    add(8, 'h800, 'h200, 0, 'h44, 0, 0, 0, 0, 0, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h800, 'h200, 0, 'h44, 0, 0, 0, 0, 0, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h800, 'h200, 0, 'h44, 0, 0, 0, 0, 0, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h800, 'h200, 0, 'h44, 0, 0, 0, 0, 1, 1, F_TPA, 'h8000000B, 'h44, 0, 0);
    add(8, 0, 'h200, 0, 'h44, 0, 0, 0, 0, 0, 1, F_RDR, 0, 0, 'h200, 'h200);
    add(8, 0, 'h200, 0, 'h44, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    // vectored timer interrupt
    add(8, 'h80, 'h1001, 0, 'h300, 0, 0, 0, 0, 1, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h80, 'h1001, 0, 'h300, 0, 0, 0, 0, 1, 1, F_TRP, 'h80000007, 'h300, 0, 0);
    add(8, 0, 'h1001, 0, 'h300, 0, 0, 0, 0, 1, 1, F_RDR, 0, 0, 'h101C, 'h1000);
    add(8, 0, 'h1001, 0, 'h300, 0, 0, 0, 0, 1, 1, F_IDL, 0, 0, 0, 0);
    // mret with ready held low, target held, new requests ignored
    add(8, 0, 'h200, 'h80, 0, 0, 0, 0, 1, 0, 0, F_MRT, 0, 0, 0, 0);
    add(8, 0, 'h200, 'h80, 0, 0, 0, 0, 0, 0, 0, F_RDR, 0, 0, 'h80, 'h80);
    add(8, 0, 'h200, 'h999, 0, 0, 0, 0, 0, 0, 0, F_RDR, 0, 0, 'h80, 'h80);
    add(8, 'h800, 'h200, 'h999, 0, 1, 3, 'h700, 1, 0, 0, F_RDR, 0, 0, 'h80, 'h80);
    add(8, 0, 'h200, 'h999, 0, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    // exception + mret + MEI together, then MEI taken
    add(8, 'h800, 'h200, 0, 'h600, 1, 2, 'h500, 1, 0, 1, F_TRP, 2, 'h500, 0, 0);
    add(8, 'h800, 'h200, 0, 'h600, 0, 0, 0, 0, 0, 0, F_RDR, 0, 0, 'h200, 'h200);
    add(8, 'h800, 'h200, 0, 'h600, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    add(8, 'h800, 'h200, 0, 'h600, 0, 0, 0, 0, 1, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h800, 'h200, 0, 'h600, 0, 0, 0, 0, 1, 1, F_TPA, 'h8000000B, 'h600, 0, 0);
    add(8, 0, 'h200, 0, 'h600, 0, 0, 0, 0, 0, 1, F_RDR, 0, 0, 'h200, 'h200);
    add(8, 0, 'h200, 0, 'h600, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    // pending withdrawn during drain
    add(8, 'h800, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, F_DRN, 0, 0, 0, 0);
    add(8, 0, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, F_DRN, 0, 0, 0, 0);
    add(8, 0, 'h200, 0, 0, 0, 0, 0, 0, 1, 1, F_IDL, 0, 0, 0, 0);
    add(8, 0, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    // exception wins in drain; sync cause stays direct even if vectored
    add(8, 'h80, 'h200, 0, 0, 0, 0, 0, 0, 0, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h80, 'h200, 0, 0, 1, 3, 'h700, 0, 0, 1, F_TRP, 3, 'h700, 0, 0);
    add(8, 'h80, 'h1001, 0, 0, 0, 0, 0, 0, 0, 1, F_RDR, 0, 0, 'h1000, 'h1000);
    add(8, 0, 'h1001, 0, 0, 0, 0, 0, 0, 0, 1, F_IDL, 0, 0, 0, 0);
    // global MIE off masks interrupts
    add(0, 'h800, 'h200, 0, 0, 0, 0, 0, 0, 1, 1, F_IDL, 0, 0, 0, 0);
    // MSI beats MTI, vectored offset 0xC
    add(8, 'h88, 'h1001, 0, 'h900, 0, 0, 0, 0, 1, 1, F_DRN, 0, 0, 0, 0);
    add(8, 'h88, 'h1001, 0, 'h900, 0, 0, 0, 0, 1, 1, F_TRP, 'h80000003, 'h900, 0, 0);
    add(8, 0, 'h1001, 0, 'h900, 0, 0, 0, 0, 1, 1, F_RDR, 0, 0, 'h100C, 'h1000);
    add(8, 0, 'h1001, 0, 'h900, 0, 0, 0, 0, 1, 1, F_IDL, 0, 0, 0, 0);

    #12;
    chk_all("reset", -1, F_IDL, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      mstatus_in = vq[i].mst; mip_in = vq[i].mip;
      mtvec_in = vq[i].mtv; mepc_in = vq[i].mepc;
      next_pc = vq[i].npc; exc_valid = vq[i].exc;
      exc_code = vq[i].code; exc_pc = vq[i].epc;
      mret_req = vq[i].mr; pipe_idle = vq[i].idle;
      redirect_ready = vq[i].rdy;
      @(posedge clk); #1;
      chk_all("vec", i, vq[i].ef, vq[i].ec, vq[i].et, vq[i].er, vq[i].er2);
    end

    // reset asserted while redirect is waiting
    mstatus_in = 32'h8; mip_in = '0; mtvec_in = 32'h200;
    exc_valid = 1'b1; exc_code = 4'd11; exc_pc = 32'h100;
    mret_req = 1'b0; pipe_idle = 1'b0; redirect_ready = 1'b0;
    @(posedge clk); #1;
    chk_all("rst_trap", 0, F_TRP, 32'hB, 32'h100, 0, 0);
    exc_valid = 1'b0;
    @(posedge clk); #1;
    chk_all("rst_redir", 1, F_RDR, 0, 0, 32'h200, 32'h200);
    reset = 1'b0;
    #1;
    chk_all("rst_async", 2, F_IDL, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1; redirect_ready = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_after", 3, F_IDL, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
